// File: rtl/pri_sel_pkg.sv
// ---------------------------------------------------------------------------
// pri_sel_pkg
// Shared definitions for the priority-select pipeline:
//   selMode_e : request mode encodings (fixed-low, fixed-high, round-robin,
//               OR-merge)
//   occ_e     : occupancy states of the two-entry output buffer
//   wrapIdx   : channel-index helper, (base + offset) wrapped into 0..n-1
// ---------------------------------------------------------------------------
package pri_sel_pkg;

    typedef enum logic [1:0] {
        MODE_LOW  = 2'b00,
        MODE_HIGH = 2'b01,
        MODE_RR   = 2'b10,
        MODE_OR   = 2'b11
    } selMode_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Both base and offset are always below n, so one subtraction is enough
    // to bring the sum back into range.
    function automatic int wrapIdx(input int base, input int offset, input int n);
        int sum;
        sum = base + offset;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/skid_buf.sv
// ---------------------------------------------------------------------------
// skid_buf
// Two-entry in-order output buffer with a registered push-side ready.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   push_valid_i   : producer offers push_data_i
//   push_ready_o   : registered; high whenever at least one entry is free
//   push_data_i    : payload to store
//   pop_valid_o    : buffer holds at least one entry
//   pop_ready_i    : consumer takes the head entry this cycle
//   pop_data_o     : head entry, held stable until popped
// ---------------------------------------------------------------------------
module skid_buf
    import pri_sel_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_valid_i,
    output logic          push_ready_o,
    input  logic [PW-1:0] push_data_i,
    output logic          pop_valid_o,
    input  logic          pop_ready_i,
    output logic [PW-1:0] pop_data_o
);

    occ_e          occ_q, occ_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic          ready_q, ready_d;
    logic          push;
    logic          pop;

    assign push         = push_valid_i & ready_q;
    assign pop          = (occ_q != OCC_EMPTY) & pop_ready_i;
    assign push_ready_o = ready_q;
    assign pop_valid_o  = (occ_q != OCC_EMPTY);
    assign pop_data_o   = head_q;

    // Occupancy and entry update. The head register always drives the
    // output, so a pop with a second entry present shifts tail into head.
    // Ready is computed from the next occupancy and registered, which keeps
    // the consumer's ready off any combinational path to the producer.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_d = push_data_i;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    head_d = push_data_i;
                end else if (push) begin
                    tail_d = push_data_i;
                    occ_d  = OCC_FULL;
                end else if (pop) begin
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
        ready_d = (occ_d != OCC_FULL);
    end

    // State registers; reset empties the buffer and holds ready low until
    // the first edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q   <= OCC_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: rtl/pri_sel_pipe.sv
// ---------------------------------------------------------------------------
// pri_sel_pipe
// Picks one of NCH data channels (or ORs them together) under a per-request
// mask and mode, and presents the result one cycle later through a
// two-entry output buffer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : request present;  in_ready : request accepted when both high
//   in_mode    : 00 fixed-low, 01 fixed-high, 10 round-robin, 11 OR-merge
//   in_mask    : per-channel enable
//   in_data    : channel c in bits [c*W +: W]
//   out_valid  : result present;   out_ready : result consumed when both high
//   out_data   : selected or merged data
//   out_ch     : winning channel index (lowest enabled index in OR-merge)
//   out_none   : no channel was enabled
// ---------------------------------------------------------------------------
module pri_sel_pipe
    import pri_sel_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 8,
    parameter int CW  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [NCH-1:0]   in_mask,
    input  logic [NCH*W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CW-1:0]    out_ch,
    output logic             out_none
);

    localparam int PW = W + CW + 1;

    logic          accept;
    logic          anySet;
    logic [CW-1:0] lowSel;
    logic [CW-1:0] highSel;
    logic [CW-1:0] rrSel;
    logic [CW-1:0] winCh;
    logic [W-1:0]  orData;
    logic [W-1:0]  winData;
    logic [W-1:0]  resData;
    logic [CW-1:0] resCh;
    logic          resNone;
    logic [CW-1:0] rrPtr_q, rrPtr_d;
    logic [PW-1:0] popData;

    assign accept = in_valid & in_ready;
    assign anySet = |in_mask;

    // Candidate winners for every mode plus the OR-merge value. Each loop
    // runs so that the preferred channel is visited last and overwrites any
    // earlier hit. The round-robin search walks offsets from the pointer
    // downward, so the first set bit at or above the pointer wins.
    always_comb begin
        lowSel  = '0;
        highSel = '0;
        rrSel   = '0;
        orData  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (in_mask[i]) begin
                lowSel = CW'(i);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (in_mask[i]) begin
                highSel = CW'(i);
                orData  = orData | in_data[i*W +: W];
            end
        end
        for (int k = NCH - 1; k >= 0; k--) begin
            for (int j = 0; j < NCH; j++) begin
                if ((j == wrapIdx(int'(rrPtr_q), k, NCH)) && in_mask[j]) begin
                    rrSel = CW'(j);
                end
            end
        end
    end

    // Mode mux and the all-zero-mask override. With nothing enabled every
    // mode reports none with zero data and channel.
    always_comb begin
        case (selMode_e'(in_mode))
            MODE_LOW:  winCh = lowSel;
            MODE_HIGH: winCh = highSel;
            MODE_RR:   winCh = rrSel;
            default:   winCh = lowSel;
        endcase
        winData = '0;
        for (int i = 0; i < NCH; i++) begin
            if (CW'(i) == winCh) begin
                winData = in_data[i*W +: W];
            end
        end
        resNone = ~anySet;
        resCh   = anySet ? winCh : '0;
        if (!anySet) begin
            resData = '0;
        end else if (selMode_e'(in_mode) == MODE_OR) begin
            resData = orData;
        end else begin
            resData = winData;
        end
    end

    // The round-robin pointer only moves on an accepted round-robin request
    // that actually found a winner; it then points just past that winner.
    always_comb begin
        rrPtr_d = rrPtr_q;
        if (accept && (selMode_e'(in_mode) == MODE_RR) && anySet) begin
            rrPtr_d = CW'(wrapIdx(int'(rrSel), 1, NCH));
        end
    end

    // Round-robin pointer register; reset restarts the rotation at channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr_q <= '0;
        end else begin
            rrPtr_q <= rrPtr_d;
        end
    end

    skid_buf #(
        .PW(PW)
    ) uOutBuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_valid_i(in_valid),
        .push_ready_o(in_ready),
        .push_data_i ({resNone, resCh, resData}),
        .pop_valid_o (out_valid),
        .pop_ready_i (out_ready),
        .pop_data_o  (popData)
    );

    assign {out_none, out_ch, out_data} = popData;

endmodule

// File: tb/tb_pri_sel_pipe.sv
// ---------------------------------------------------------------------------
// tb_pri_sel_pipe
// Table-driven bench for pri_sel_pipe (NCH=4, W=8). Every accepted request
// pushes its expected result into a queue; a monitor pops and compares each
// result as it leaves the DUT, so ordering, loss and duplication all show up.
// ---------------------------------------------------------------------------
module tb_pri_sel_pipe;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int CW  = 2;
    localparam int NVEC = 18;
    localparam logic [31:0] DEF = {8'd44, 8'd33, 8'd22, 8'd11};

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [7:0]  expData;
        logic [1:0]  expCh;
        logic        expNone;
    } vec_t;

    typedef struct packed {
        logic       none;
        logic [1:0] ch;
        logic [7:0] data;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [NCH-1:0]   in_mask;
    logic [NCH*W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [CW-1:0]    out_ch;
    logic             out_none;

    int   checks = 0;
    int   errors = 0;
    int   readyCtl = 1;
    res_t expQ[$];
    vec_t vecs[NVEC];

    pri_sel_pipe #(
        .NCH(NCH),
        .W  (W),
        .CW (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_mask  (in_mask),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_none (out_none)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Consumer ready: held low, held high or randomised, switched just after
    // each rising edge so it is stable across the following edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (readyCtl)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Result monitor: a handshake seen at the falling edge completes on the
    // next rising edge, so the head of the scoreboard is compared here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checkOutput();
        end
    end

    // Hard stop in case something wedges the stimulus loops.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        res_t exp;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_output: got data=%0d ch=%0d none=%0d, required no output",
                     out_data, out_ch, out_none);
        end else begin
            exp = expQ.pop_front();
            if ({out_none, out_ch, out_data} !== exp) begin
                errors++;
                $display("[TB] FAIL out_result: got data=%0d ch=%0d none=%0d, required data=%0d ch=%0d none=%0d",
                         out_data, out_ch, out_none, exp.data, exp.ch, exp.none);
            end
        end
    endtask

    // Offer one request and hold it until accepted (bounded), recording the
    // expected result at the moment of acceptance.
    task automatic applyStimulus(input vec_t v);
        int n = 0;
        res_t r;
        in_valid = 1'b1;
        in_mode  = v.mode;
        in_mask  = v.mask;
        in_data  = v.data;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for %0d cycles, required acceptance", n);
        end else begin
            r.none = v.expNone;
            r.ch   = v.expCh;
            r.data = v.expData;
            expQ.push_back(r);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Asynchronous reset assertion mid-cycle, with checks of the reset state
    // and of ready rising on the first edge after release.
    task automatic doReset();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkValue("rst_out_valid", 32'(out_valid), 32'd0);
        checkValue("rst_in_ready", 32'(in_ready), 32'd0);
        checkValue("rst_out_data", 32'(out_data), 32'd0);
        checkValue("rst_out_ch", 32'(out_ch), 32'd0);
        checkValue("rst_out_none", 32'(out_none), 32'd0);
        expQ.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkValue("ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        checkValue("ready_after_edge", 32'(in_ready), 32'd1);
    endtask

    task automatic waitDrain();
        int n = 0;
        in_valid = 1'b0;
        while ((expQ.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checkValue("drain_queue", 32'(expQ.size()), 32'd0);
        checkValue("drain_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic runTable();
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
        end
    endtask

    initial begin
        in_valid = 1'b0;
        in_mode  = 2'b00;
        in_mask  = '0;
        in_data  = '0;

        // Sequence starts right after reset, so the round-robin pointer is 0.
        vecs[0]  = '{2'b00, 4'b0110, DEF, 8'd22, 2'd1, 1'b0};
        vecs[1]  = '{2'b01, 4'b0110, DEF, 8'd33, 2'd2, 1'b0};
        vecs[2]  = '{2'b11, 4'b0101, {8'hFF, 8'hA0, 8'hFF, 8'h0F}, 8'hAF, 2'd0, 1'b0};
        vecs[3]  = '{2'b11, 4'b1110, DEF, 8'd63, 2'd1, 1'b0};
        vecs[4]  = '{2'b00, 4'b0000, DEF, 8'd0, 2'd0, 1'b1};
        vecs[5]  = '{2'b01, 4'b0000, DEF, 8'd0, 2'd0, 1'b1};
        vecs[6]  = '{2'b10, 4'b0000, DEF, 8'd0, 2'd0, 1'b1};
        vecs[7]  = '{2'b11, 4'b0000, DEF, 8'd0, 2'd0, 1'b1};
        vecs[8]  = '{2'b10, 4'b1111, DEF, 8'd11, 2'd0, 1'b0};
        vecs[9]  = '{2'b10, 4'b1111, DEF, 8'd22, 2'd1, 1'b0};
        vecs[10] = '{2'b10, 4'b0000, DEF, 8'd0, 2'd0, 1'b1};
        vecs[11] = '{2'b10, 4'b1111, DEF, 8'd33, 2'd2, 1'b0};
        vecs[12] = '{2'b10, 4'b1111, DEF, 8'd44, 2'd3, 1'b0};
        vecs[13] = '{2'b10, 4'b1111, DEF, 8'd11, 2'd0, 1'b0};
        vecs[14] = '{2'b10, 4'b0101, DEF, 8'd33, 2'd2, 1'b0};
        vecs[15] = '{2'b10, 4'b0011, DEF, 8'd11, 2'd0, 1'b0};
        vecs[16] = '{2'b01, 4'b1001, DEF, 8'd44, 2'd3, 1'b0};
        vecs[17] = '{2'b00, 4'b1000, DEF, 8'd44, 2'd3, 1'b0};

        @(posedge clk);
        #1;
        doReset();

        // Streaming pass with the consumer always ready.
        readyCtl = 1;
        runTable();

        // Idle round-robin requests must not move the pointer (still at 1).
        in_valid = 1'b0;
        in_mode  = 2'b10;
        in_mask  = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        applyStimulus('{2'b10, 4'b1111, DEF, 8'd22, 2'd1, 1'b0});
        waitDrain();

        // Consumer stalls: two results fill the buffer, the third waits.
        readyCtl = 0;
        applyStimulus('{2'b00, 4'b0001, 32'h0000_0001, 8'd1, 2'd0, 1'b0});
        applyStimulus('{2'b01, 4'b0010, 32'h0000_0200, 8'd2, 2'd1, 1'b0});
        in_valid = 1'b1;
        in_mode  = 2'b00;
        in_mask  = 4'b0100;
        in_data  = 32'h0003_0000;
        repeat (3) begin
            @(negedge clk);
            checkValue("full_in_ready", 32'(in_ready), 32'd0);
            checkValue("full_out_valid", 32'(out_valid), 32'd1);
            checkValue("hold_out_data", 32'(out_data), 32'd1);
            checkValue("hold_out_ch", 32'(out_ch), 32'd0);
            checkValue("hold_out_none", 32'(out_none), 32'd0);
        end
        @(posedge clk);
        #1;
        readyCtl = 1;
        applyStimulus('{2'b00, 4'b0100, 32'h0003_0000, 8'd3, 2'd2, 1'b0});
        checkValue("push_pop_ready", 32'(in_ready), 32'd1);
        checkValue("push_pop_valid", 32'(out_valid), 32'd1);
        waitDrain();

        // Same table again from reset, with a randomly stalling consumer.
        doReset();
        readyCtl = 2;
        runTable();
        readyCtl = 1;
        waitDrain();

        // Reset with two buffered results and the pointer at 2.
        doReset();
        readyCtl = 0;
        applyStimulus('{2'b10, 4'b1111, DEF, 8'd11, 2'd0, 1'b0});
        applyStimulus('{2'b10, 4'b1111, DEF, 8'd22, 2'd1, 1'b0});
        doReset();
        readyCtl = 1;
        applyStimulus('{2'b10, 4'b1111, DEF, 8'd11, 2'd0, 1'b0});
        waitDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pri_sel_pipe.md
PRI_SEL_PIPE -- requirements
Module: pri_sel_pipe

Interface
REQ-001 SHALL have parameter NCH, default 4, number of input channels (2..16).
REQ-002 SHALL have parameter W, default 8, data width per channel (1..32).
REQ-003 SHALL have parameter CW, default $clog2(NCH), channel-index width.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  request accepted when in_valid & in_ready.
REQ-008 in_mode  input  2  00 fixed-low, 01 fixed-high, 10 round-robin, 11 OR-merge.
REQ-009 in_mask  input  NCH  per-channel enable.
REQ-010 in_data  input  NCH*W  channel c in bits [c*W +: W].
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  result consumed when out_valid & out_ready.
REQ-013 out_data  output  W  selected or merged data.
REQ-014 out_ch  output  CW  winning channel index.
REQ-015 out_none  output  1  no channel enabled in in_mask.

Function
REQ-016 SHALL compute the result from in_mask, in_mode and in_data in the accept cycle and present it registered on the next cycle (latency 1).
REQ-017 Mode 00 SHALL select the lowest-index set mask bit; mode 01 the highest-index set bit.
REQ-018 Mode 10 SHALL select the first set bit at or above rr_ptr, wrapping from NCH-1 to 0; after an accept in mode 10 with any bit set, rr_ptr SHALL become (winner+1) mod NCH.
REQ-019 rr_ptr SHALL change only on an accepted mode-10 request with a nonzero mask.
REQ-020 Mode 11 SHALL output the bitwise OR of all enabled channels' data; out_ch SHALL be the lowest enabled index.
REQ-021 When in_mask is all zero, out_none SHALL be 1, out_data 0 and out_ch 0, in every mode.
REQ-022 Output stage SHALL be a 2-entry skid buffer: in_ready SHALL be 1 whenever at least one entry is free, and SHALL be a registered signal with no combinational path from out_ready.
REQ-023 A transfer SHALL not be lost or duplicated under any out_ready pattern; results SHALL leave in acceptance order.
REQ-024 Simultaneous accept and drain with one entry full SHALL keep occupancy at 1 and in_ready at 1.
REQ-025 With both entries full, in_ready SHALL be 0 and out_data/out_ch/out_none SHALL hold stable until drained.
REQ-026 out_valid SHALL be 1 exactly when occupancy is nonzero.
REQ-027 Inputs with in_valid=0 SHALL have no effect on any state.

Reset
REQ-028 While rst_n=0: out_valid=0, in_ready=0, out_data=0, out_ch=0, out_none=0, rr_ptr=0, occupancy 0.
REQ-029 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-030 Reset mid-transfer SHALL discard buffered results and restart round-robin at channel 0.

Structure
REQ-031 Mode encodings and a channel-index helper function SHALL reside in shared package pri_sel_pkg.
REQ-032 The skid buffer SHALL be a separate sub-module skid_buf parameterised by payload width (W+CW+1).
REQ-033 Selection logic SHALL be parameterised loops; no per-NCH hand-coding.

Verification
REQ-034 NCH=4, W=8, mode 00, mask 0110, data {D3=44,D2=33,D1=22,D0=11} -> next cycle out_data=22, out_ch=1, out_none=0.
REQ-035 Mode 10, mask 1111, four back-to-back accepts, out_ready=1 -> out_ch 0,1,2,3; fifth accept -> 0.
REQ-036 Mode 11, mask 0101, D0=0x0F, D2=0xA0 -> out_data=0xAF, out_ch=0.
REQ-037 Mask 0000 in each of the four modes -> out_none=1, out_data=0, out_ch=0, rr_ptr unchanged.
REQ-038 out_ready=0 for 3 cycles with in_valid=1 -> two results buffered, in_ready=0; release -> both delivered in order, no loss.
REQ-039 Assert rst_n=0 with two buffered results and rr_ptr=2 -> out_valid=0 immediately; after release, mode 10, mask 1111 -> out_ch=0.
